mux_arb_rtl: RTL and testbench

- Parametrised successor to the team's fixed 8-way select mux: an N-input arbitrated mux with a valid/ready handshake on every input and on the output.
- Each cycle it picks one valid requester and captures its payload into a one-entry output register, then holds it until the consumer accepts.
- Used for shared-resource front-ends in the TinyRV1 datapath, e.g. a memory port shared by fetch and load/store.

---
 rtl/mux_arb_rtl.sv | 86 ++++++++
 tb/tb_mux_arb_rtl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mux_arb_rtl.sv
// N-input arbitrated mux with valid/ready on every input and a one-entry output register.
// Define MUX_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority.
module mux_arb_rtl #(
  parameter int p_nbits  = 32,
  parameter int p_nreqs  = 4,
  localparam int p_idbits = $clog2(p_nreqs)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [p_nreqs-1:0]           in_val,
  input  logic [p_nreqs*p_nbits-1:0]   in_data,
  output logic [p_nreqs-1:0]           in_rdy,
  output logic                         out_val,
  output logic [p_nbits-1:0]           out_data,
  output logic [p_idbits-1:0]          out_id,
  input  logic                         out_rdy
);

  logic                vld_p0;
  logic [p_nbits-1:0]  data_p0;
  logic [p_idbits-1:0] id_p0;
  logic [p_idbits-1:0] ptr;
  logic [p_nreqs-1:0]  grant;
  logic [p_idbits-1:0] grant_id;
  logic                free;
  logic                xfer_in;
  logic                xfer_out;

  function automatic logic [p_idbits-1:0] next_ptr(input logic [p_idbits-1:0] k);
    if (int'(k) == p_nreqs - 1) return '0;
    return k + 1'b1;
  endfunction

  // A draining register can be refilled in the same cycle.
  assign free     = !vld_p0 || out_rdy;
  assign in_rdy   = grant & {p_nreqs{free}} & {p_nreqs{!rst}};
  assign xfer_in  = |in_rdy;
  assign xfer_out = vld_p0 && out_rdy;

  always_comb begin
    int  idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int j = 0; j < p_nreqs; j++) begin
      idx = int'(ptr) + j;
      if (idx >= p_nreqs) idx = idx - p_nreqs;
      if (!found && in_val[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = p_idbits'(idx);
      end
    end
  end

`ifdef MUX_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (xfer_in) ptr <= next_ptr(grant_id);
  end
`else
  assign ptr = '0;
`endif

  // Stage p0: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      id_p0   <= '0;
    end else if (xfer_in) begin
      vld_p0  <= 1'b1;
      data_p0 <= in_data[int'(grant_id)*p_nbits +: p_nbits];
      id_p0   <= grant_id;
    end else if (xfer_out) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_val  = vld_p0;
  assign out_data = data_p0;
  assign out_id   = id_p0;

endmodule

// File: tb/tb_mux_arb_rtl.sv
// Directed bench for mux_arb_rtl (p_nbits=8, p_nreqs=4); expectations follow MUX_ARB_ROUND_ROBIN_EN.
module tb_mux_arb_rtl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_val;
  logic [31:0] in_data;
  logic [3:0]  in_rdy;
  logic        out_val;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_rdy;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BASE = {8'h44, 8'h33, 8'h3C, 8'h11};

  mux_arb_rtl #(.p_nbits(8), .p_nreqs(4)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_data(in_data), .in_rdy(in_rdy),
    .out_val(out_val), .out_data(out_data), .out_id(out_id), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rot_ids [5];
    logic [1:0] drop_ids [2];
    logic [3:0] refill_rdy, after_idle_rdy;
    logic [1:0] refill_id;
    logic [7:0] refill_data;
`ifdef MUX_ARB_ROUND_ROBIN_EN
    rot_ids        = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    drop_ids       = '{2'd1, 2'd2};
    refill_rdy     = 4'b0100;
    refill_id      = 2'd2;
    refill_data    = 8'h33;
    after_idle_rdy = 4'b0010;
`else
    rot_ids        = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    drop_ids       = '{2'd1, 2'd1};
    refill_rdy     = 4'b0001;
    refill_id      = 2'd0;
    refill_data    = 8'h11;
    after_idle_rdy = 4'b0001;
`endif

    rst = 1'b0; in_val = 4'b1111; in_data = BASE; out_rdy = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_val", out_val, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_in_rdy", in_rdy, 0);

    @(negedge clk) rst = 1'b0;
    #1 chk("post_rst_in_rdy", in_rdy, 4'b0001);
    tick();
    chk("first_val", out_val, 1);
    chk("first_id", out_id, 0);
    chk("first_data", out_data, 8'h11);
    chk("stall_in_rdy", in_rdy, 0);

    // Single request on ch2
    in_val = 4'b0100; in_data = {8'h44, 8'hA5, 8'h3C, 8'h11}; out_rdy = 1'b1;
    #1 chk("single_in_rdy", in_rdy, 4'b0100);
    tick();
    chk("single_val", out_val, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_id", out_id, 2);

    // Rotation from a freshly reset pointer
    in_val = 4'b0000; in_data = BASE;
    rst = 1'b1; #1 rst = 1'b0; #1;
    chk("midrst_out_val", out_val, 0);
    in_val = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rot_id%0d", i), out_id, rot_ids[i]);
      chk($sformatf("rot_val%0d", i), out_val, 1);
    end
    in_val = 4'b1110;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("drop_id%0d", i), out_id, drop_ids[i]);
    end

    // Backpressure holding ch1
    in_val = 4'b0000;
    rst = 1'b1; #1 rst = 1'b0; #1;
    in_val = 4'b0010;
    tick();
    chk("bp_load_id", out_id, 1);
    chk("bp_load_data", out_data, 8'h3C);
    out_rdy = 1'b0; in_val = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp_in_rdy%0d", i), in_rdy, 0);
      tick();
      chk($sformatf("bp_data%0d", i), out_data, 8'h3C);
      chk($sformatf("bp_val%0d", i), out_val, 1);
      chk($sformatf("bp_id%0d", i), out_id, 1);
    end
    out_rdy = 1'b1;
    #1 chk("refill_in_rdy", in_rdy, refill_rdy);
    tick();
    chk("refill_id", out_id, refill_id);
    chk("refill_data", out_data, refill_data);
    chk("refill_val", out_val, 1);

    // Reset pulse while stalled
    out_rdy = 1'b0;
    tick();
    chk("stall2_val", out_val, 1);
    rst = 1'b1;
    #1;
    chk("rststall_val", out_val, 0);
    chk("rststall_data", out_data, 0);
    chk("rststall_in_rdy", in_rdy, 0);
    rst = 1'b0;
    #1 chk("rststall_rel_rdy", in_rdy, 4'b0001);
    tick();
    chk("rststall_id", out_id, 0);
    chk("rststall_gdata", out_data, 8'h11);

    // Idle with free slot: drain, hold data, pointer unchanged
    in_val = 4'b0000; out_rdy = 1'b1;
    #1 chk("idle_in_rdy", in_rdy, 0);
    tick();
    chk("idle_val", out_val, 0);
    chk("idle_data_hold", out_data, 8'h11);
    chk("idle_id_hold", out_id, 0);
    tick();
    in_val = 4'b1111;
    #1 chk("after_idle_rdy", in_rdy, after_idle_rdy);
    tick();
    chk("after_idle_val", out_val, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
